// File: rtl/ysyx_25060170_ifu_fetch.sv
// rtl/ysyx_25060170_ifu_fetch.sv - instruction fetch unit: owns the PC, fetches words, presents them to the IDU
// Optional macro IFU_MISALIGN_CHK_EN: misaligned jump/flush targets park the unit in S_ERR.
module ysyx_25060170_ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   input  logic        jump_en,
   input  logic [31:0] jump_pc,
   input  logic        flush_i,
   input  logic [31:0] flush_pc,
   output logic        misalign_o
);

`ifdef IFU_MISALIGN_CHK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;
`endif

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_q, inst_nxt;
   logic [31:0] tgt;
   logic        drop, drop_nxt;
   logic        load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         drop   <= 1'b0;
         inst_q <= 32'h0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         drop   <= drop_nxt;
         inst_q <= inst_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      drop_nxt  = drop;
      inst_nxt  = inst_q;
      load      = 1'b0;
      tgt       = flush_pc;

      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            // a flush racing the accept leaves a stale request in flight
            if (mem_req_ready) begin
               state_nxt = S_WAIT;
               drop_nxt  = flush_i;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               drop_nxt = 1'b0;
               if (drop || flush_i) begin
                  state_nxt = S_REQ;
               end else begin
                  inst_nxt  = mem_rsp_data;
                  state_nxt = S_OUT;
               end
            end else if (flush_i) begin
               drop_nxt = 1'b1;
            end
         end
         S_OUT: begin
            if (flush_i || inst_ready) state_nxt = S_REQ;
         end
`ifdef IFU_MISALIGN_CHK_EN
         S_ERR: begin
            if (mem_rsp_valid) drop_nxt = 1'b0;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase

      // flush outranks the decode-stage redirect
      if (flush_i) begin
         load = 1'b1;
      end else if (state == S_OUT && inst_ready) begin
         if (jump_en) begin
            load = 1'b1;
            tgt  = jump_pc;
         end else begin
            pc_nxt = pc + 32'd4;
         end
      end

      if (load) begin
`ifdef IFU_MISALIGN_CHK_EN
         pc_nxt = tgt;
         if (tgt[1:0] != 2'b00) begin
            state_nxt = S_ERR;
         end else if (state == S_ERR) begin
            // a request still in flight must drain before a new one is issued
            state_nxt = (drop && !mem_rsp_valid) ? S_WAIT : S_REQ;
         end
`else
         pc_nxt = tgt & 32'hFFFF_FFFC;
`endif
      end
   end

   assign mem_req_valid = (state == S_REQ);
   assign mem_req_addr  = pc;
   assign inst_valid    = (state == S_OUT);
   assign pc_o          = pc;
   assign inst_o        = inst_q;
`ifdef IFU_MISALIGN_CHK_EN
   assign misalign_o    = (state == S_ERR);
`else
   assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// tb/tb_ysyx_25060170_ifu_fetch.sv - self-checking bench for ysyx_25060170_ifu_fetch
module tb_ysyx_25060170_ifu_fetch;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        jump_en;
   logic [31:0] jump_pc;
   logic        flush_i;
   logic [31:0] flush_pc;
   logic        misalign_o;

   int          n_cmp = 0;
   int          n_err = 0;
   int          lat_fix;
   logic        rdy_rand;
   logic        chk_req;
   logic [31:0] exp_pc;
   logic        acc_flag;
   logic [31:0] acc_addr;

   ysyx_25060170_ifu_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .jump_en       (jump_en),
      .jump_pc       (jump_pc),
      .flush_i       (flush_i),
      .flush_pc      (flush_pc),
      .misalign_o    (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_inst(input string tag);
      int k = 0;
      while (inst_valid !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'b0, inst_valid}, 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (mem_req_valid !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'b0, mem_req_valid}, 32'd1);
   endtask

   task automatic handshake(input logic j, input logic [31:0] jp, input logic f, input logic [31:0] fp);
      inst_ready = 1'b1;
      jump_en    = j;
      jump_pc    = jp;
      flush_i    = f;
      flush_pc   = fp;
      @(negedge clk);
      inst_ready = 1'b0;
      jump_en    = 1'b0;
      flush_i    = 1'b0;
   endtask

   // records every accepted request; in the random phase its address must be the model's next pc
   always @(posedge clk) begin
      if (rst_n && mem_req_valid && mem_req_ready) begin
         acc_flag = 1'b1;
         acc_addr = mem_req_addr;
         if (chk_req) check("req_addr_rand", mem_req_addr, exp_pc);
      end
   end

   // memory: one response per accepted request, lat_fix cycles later (0 = random 1..4)
   initial begin : mem_model
      int          cnt;
      logic [31:0] raddr;
      cnt           = 0;
      raddr         = 32'h0;
      acc_flag      = 1'b0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_rsp_valid = 1'b0;
         if (!rst_n) begin
            cnt      = 0;
            acc_flag = 1'b0;
         end else begin
            if (acc_flag) begin
               acc_flag = 1'b0;
               cnt      = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
               raddr    = acc_addr;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_data  = mem_word(raddr);
               end
            end
         end
         mem_req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   initial begin
      int          k;
      logic        seen;
      logic        j;
      logic [31:0] t;
      rst_n      = 1'b1;
      inst_ready = 1'b0;
      jump_en    = 1'b0;
      jump_pc    = 32'h0;
      flush_i    = 1'b0;
      flush_pc   = 32'h0;
      lat_fix    = 1;
      rdy_rand   = 1'b0;
      chk_req    = 1'b0;
      exp_pc     = 32'h8000_0000;

      #2 rst_n = 1'b0;
      #1;
      check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_misalign", {31'b0, misalign_o}, 32'd0);
      check("rst_inst_o", inst_o, 32'h0);
      check("rst_pc_o", pc_o, 32'h8000_0000);
      check("rst_req_addr", mem_req_addr, 32'h8000_0000);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("idle_no_req", {31'b0, mem_req_valid}, 32'd0);
      @(negedge clk);
      check("first_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("first_req_addr", mem_req_addr, 32'h8000_0000);

      wait_inst("first_inst_valid");
      check("first_pc_o", pc_o, 32'h8000_0000);
      check("first_inst_o", inst_o, 32'h0000_0413);

      // IDU stalls for five cycles
      repeat (5) begin
         @(negedge clk);
         check("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
         check("hold_pc_o", pc_o, 32'h8000_0000);
         check("hold_inst_o", inst_o, 32'h0000_0413);
         check("hold_no_req", {31'b0, mem_req_valid}, 32'd0);
      end
      handshake(1'b0, 32'h0, 1'b0, 32'h0);
      wait_req("seq_req");
      check("seq_addr", mem_req_addr, 32'h8000_0004);

      wait_inst("jmp_inst");
      check("jmp_pc_o", pc_o, 32'h8000_0004);
      check("jmp_inst_o", inst_o, mem_word(32'h8000_0004));
      handshake(1'b1, 32'h8000_0100, 1'b0, 32'h0);
      wait_req("jmp_req");
      check("jmp_addr", mem_req_addr, 32'h8000_0100);

      // flush while the 8000_0100 fetch is outstanding; its response arrives 3 cycles after the flush
      lat_fix = 4;
      @(negedge clk);
      check("wait_no_req", {31'b0, mem_req_valid}, 32'd0);
      flush_i  = 1'b1;
      flush_pc = 32'h8000_0200;
      @(negedge clk);
      flush_i = 1'b0;
      k    = 0;
      seen = 1'b0;
      while (mem_req_valid !== 1'b1 && k < 10) begin
         if (inst_valid === 1'b1) seen = 1'b1;
         @(negedge clk);
         k++;
      end
      lat_fix = 1;
      check("flush_wait_cycles", k, 32'd3);
      check("flush_no_stale", {31'b0, seen}, 32'd0);
      check("flush_addr", mem_req_addr, 32'h8000_0200);
      wait_inst("flush_inst");
      check("flush_pc_o", pc_o, 32'h8000_0200);
      check("flush_inst_o", inst_o, mem_word(32'h8000_0200));

      handshake(1'b1, 32'h8000_0300, 1'b1, 32'h8000_0400);
      wait_req("fj_req");
      check("fj_addr", mem_req_addr, 32'h8000_0400);

      wait_inst("wrap_setup_inst");
      handshake(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      wait_inst("wrap_inst");
      check("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
      handshake(1'b0, 32'h0, 1'b0, 32'h0);
      wait_req("wrap_req");
      check("wrap_addr", mem_req_addr, 32'h0000_0000);

      wait_inst("mis_inst");
      check("mis_pc_o_before", pc_o, 32'h0000_0000);
      handshake(1'b1, 32'h8000_0102, 1'b0, 32'h0);
`ifdef IFU_MISALIGN_CHK_EN
      check("mis_flag", {31'b0, misalign_o}, 32'd1);
      check("mis_pc_o", pc_o, 32'h8000_0102);
      seen = 1'b0;
      repeat (4) begin
         if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      check("mis_quiet", {31'b0, seen}, 32'd0);
      flush_i  = 1'b1;
      flush_pc = 32'h8000_0006;
      @(negedge clk);
      flush_i = 1'b0;
      check("mis_reflush_flag", {31'b0, misalign_o}, 32'd1);
      check("mis_reflush_pc", pc_o, 32'h8000_0006);
      flush_i  = 1'b1;
      flush_pc = 32'h8000_0000;
      @(negedge clk);
      flush_i = 1'b0;
      check("mis_clear", {31'b0, misalign_o}, 32'd0);
      wait_req("mis_recover_req");
      check("mis_recover_addr", mem_req_addr, 32'h8000_0000);
      exp_pc = 32'h8000_0000;
`else
      check("mis_flag_off", {31'b0, misalign_o}, 32'd0);
      wait_req("mis_req");
      check("mis_addr", mem_req_addr, 32'h8000_0100);
      exp_pc = 32'h8000_0100;
`endif

      // random phase: model is the architectural pc sequence
      lat_fix  = 0;
      rdy_rand = 1'b1;
      chk_req  = 1'b1;
      for (int n = 0; n < 40; n++) begin
         wait_inst("rand_inst_valid");
         check("rand_pc_o", pc_o, exp_pc);
         check("rand_inst_o", inst_o, mem_word(exp_pc));
         repeat ($urandom_range(0, 2)) begin
            jump_en = 1'b1;
            jump_pc = $urandom;
            @(negedge clk);
         end
         j = ($urandom_range(0, 2) == 0);
         t = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
`ifndef IFU_MISALIGN_CHK_EN
         t[1:0] = 2'($urandom_range(0, 3));
`endif
         handshake(j, t, 1'b0, 32'h0);
         exp_pc = j ? (t & 32'hFFFF_FFFC) : exp_pc + 32'd4;
      end

      chk_req = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("arst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("arst_pc_o", pc_o, 32'h8000_0000);
      check("arst_inst_o", inst_o, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
